// File: rtl/golf_input_ctrl.sv
// Player-input front end: synchronizes and debounces the buttons, derives pan/frame/new-game
// strobes and runs the hit-arming FSM and stroke counter in front of gameplay.

module golf_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          synced;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module golf_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NEW_GAME_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       btn_hit_in,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       btn_new_in,
    input  logic       vsync_in,
    input  logic [2:0] state_in,
    output logic       charging_hit,
    output logic       camera_pan_left,
    output logic       camera_pan_right,
    output logic       new_frame,
    output logic       new_game,
    output logic [7:0] strokes
);
    localparam int NUM_BTN = 4;
    localparam int NGW     = $clog2(NEW_GAME_CYCLES + 1);
    localparam logic [NGW-1:0] NG_LOAD = NGW'(NEW_GAME_CYCLES);

    localparam logic [2:0] ST_RESTING  = 3'd0;
    localparam logic [2:0] ST_CHARGING = 3'd1;
    localparam logic [2:0] ST_ON_HIT   = 3'd2;

    typedef struct packed {
        logic new_btn;
        logic right;
        logic left;
        logic hit;
    } btn_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CHARGING = 2'd2
    } hit_state_t;

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] stable_btn;
    btn_t               db;

    assign raw_btn = {btn_new_in, btn_right_in, btn_left_in, btn_hit_in};
    assign db      = btn_t'(stable_btn);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        golf_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk_in),
            .rst_n  (rst_n_in),
            .raw    (raw_btn[i]),
            .stable (stable_btn[i])
        );
    end

    // Aim is frozen while the shot is being charged or struck.
    logic pan_ok;
    logic vsync_prev;

    assign pan_ok = (state_in != ST_CHARGING) && (state_in != ST_ON_HIT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            camera_pan_left  <= 1'b0;
            camera_pan_right <= 1'b0;
            vsync_prev       <= 1'b0;
            new_frame        <= 1'b0;
        end else begin
            camera_pan_left  <= db.left & ~db.right & pan_ok;
            camera_pan_right <= db.right & ~db.left & pan_ok;
            vsync_prev       <= vsync_in;
            new_frame        <= vsync_in & ~vsync_prev;
        end
    end

    logic           new_prev;
    logic           new_rise;
    logic [NGW-1:0] ng_cnt;

    assign new_rise = db.new_btn & ~new_prev;

    // Reset leaves the counter loaded, so gameplay sees a full pulse after power-up.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            new_prev <= 1'b0;
            ng_cnt   <= NG_LOAD;
            new_game <= 1'b1;
        end else begin
            new_prev <= db.new_btn;
            if (new_rise) begin
                ng_cnt   <= NG_LOAD;
                new_game <= 1'b1;
            end else if (ng_cnt != '0) begin
                ng_cnt   <= ng_cnt - NGW'(1);
                new_game <= (ng_cnt != NGW'(1));
            end else begin
                new_game <= 1'b0;
            end
        end
    end

    hit_state_t hit_st;

    assign charging_hit = (hit_st == CHARGING);

    // Arming needs the button seen released at rest, so a held button never auto-fires.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_st  <= IDLE;
            strokes <= 8'd0;
        end else if (new_game) begin
            hit_st  <= IDLE;
            strokes <= 8'd0;
        end else begin
            case (hit_st)
                IDLE: begin
                    if (!db.hit && state_in == ST_RESTING) hit_st <= ARMED;
                end
                ARMED: begin
                    if (state_in != ST_RESTING) hit_st <= IDLE;
                    else if (db.hit)            hit_st <= CHARGING;
                end
                CHARGING: begin
                    if (!db.hit) begin
                        hit_st <= IDLE;
                        if (strokes != 8'd255) strokes <= strokes + 8'd1;
                    end
                end
                default: hit_st <= IDLE;
            endcase
        end
    end
endmodule
